// File: rtl/issue_sched.sv
// issue_sched: reservation-station scheduler with CDB wakeup and oldest-ready (min PC) issue
// Ports: clock/reset (async active-high); disp_* dispatch request and op fields, disp_ready when a
// free entry exists; cdb_valid/cdb_tag wakeup broadcast; squash flushes all ops; iss_* valid/ready
// issue register toward the FU; occupancy counts valid entries excluding the issue register.
module issue_sched #(
  parameter int N_ENT = 16,
  parameter int TAG_W = 6,
  parameter int PC_W  = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [PC_W-1:0]            disp_pc,
  input  logic [TAG_W-1:0]           disp_tag1,
  input  logic [TAG_W-1:0]           disp_tag2,
  input  logic                       disp_rdy1,
  input  logic                       disp_rdy2,
  input  logic [TAG_W-1:0]           disp_dest,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic                       squash,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic [PC_W-1:0]            iss_pc,
  output logic [TAG_W-1:0]           iss_dest,
  output logic [$clog2(N_ENT)-1:0]   iss_idx,
  output logic [$clog2(N_ENT+1)-1:0] occupancy
);
  localparam int IW = $clog2(N_ENT);
  localparam int OW = $clog2(N_ENT+1);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t st;
  logic [N_ENT-1:0] vld, rdy1, rdy2;
  logic [PC_W-1:0] pc [N_ENT];
  logic [TAG_W-1:0] tag1 [N_ENT];
  logic [TAG_W-1:0] tag2 [N_ENT];
  logic [TAG_W-1:0] dest [N_ENT];
  logic [IW-1:0] fidx, widx;
  logic [PC_W-1:0] wpc;
  logic found, fire, load;
  assign disp_ready = ~&vld;
  assign iss_valid = st == FULL;
  assign fire = disp_valid & disp_ready & ~squash;
  assign load = found & (st == EMPTY | iss_ready);
  // ascending scan: the last free slot seen is the highest-index one
  always_comb begin
    fidx = '0;
    for (int i = 0; i < N_ENT; i++)
      if (!vld[i]) fidx = IW'(i);
  end
  // ascending scan with <= so that on equal PCs the higher index wins
  always_comb begin
    found = 1'b0;
    widx = '0;
    wpc = '0;
    for (int i = 0; i < N_ENT; i++)
      if (vld[i] & rdy1[i] & rdy2[i] & (!found | pc[i] <= wpc)) begin
        found = 1'b1;
        widx = IW'(i);
        wpc = pc[i];
      end
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      vld <= '0;
      rdy1 <= '0;
      rdy2 <= '0;
      st <= EMPTY;
      iss_pc <= '0;
      iss_dest <= '0;
      iss_idx <= '0;
      occupancy <= '0;
    end else if (squash) begin
      vld <= '0;
      st <= EMPTY;
      occupancy <= '0;
    end else begin
      for (int i = 0; i < N_ENT; i++) begin
        if (vld[i] & cdb_valid & tag1[i] == cdb_tag) rdy1[i] <= 1'b1;
        if (vld[i] & cdb_valid & tag2[i] == cdb_tag) rdy2[i] <= 1'b1;
      end
      // a broadcast in the dispatch cycle would otherwise be missed by the new entry
      if (fire) begin
        vld[fidx] <= 1'b1;
        rdy1[fidx] <= disp_rdy1 | (cdb_valid & disp_tag1 == cdb_tag);
        rdy2[fidx] <= disp_rdy2 | (cdb_valid & disp_tag2 == cdb_tag);
      end
      if (load) begin
        vld[widx] <= 1'b0;
        iss_pc <= wpc;
        iss_dest <= dest[widx];
        iss_idx <= widx;
      end
      st <= load ? FULL : (iss_ready ? EMPTY : st);
      occupancy <= occupancy + OW'(fire) - OW'(load);
    end
  always_ff @(posedge clock)
    if (fire) begin
      pc[fidx] <= disp_pc;
      tag1[fidx] <= disp_tag1;
      tag2[fidx] <= disp_tag2;
      dest[fidx] <= disp_dest;
    end
endmodule

// File: tb/tb_issue_sched.sv
// tb_issue_sched: table-driven and directed checks of the issue scheduler
module tb_issue_sched;
  logic clock, reset, disp_valid, disp_ready, disp_rdy1, disp_rdy2, cdb_valid, squash;
  logic iss_valid, iss_ready;
  logic [31:0] disp_pc, iss_pc;
  logic [5:0] disp_tag1, disp_tag2, disp_dest, cdb_tag, iss_dest;
  logic [3:0] iss_idx;
  logic [4:0] occupancy;
  int checks = 0, errors = 0;
  typedef struct {
    logic dv; logic [31:0] pc; logic [5:0] t1, t2; logic r1, r2; logic [5:0] dest;
    logic cv; logic [5:0] ct; logic ir;
    logic e_iv; logic [31:0] e_pc; logic [5:0] e_dest; logic [3:0] e_idx; logic [4:0] e_occ;
  } vec_t;
  vec_t tbl [26];
  issue_sched dut (
    .clock(clock), .reset(reset), .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_pc(disp_pc), .disp_tag1(disp_tag1), .disp_tag2(disp_tag2), .disp_rdy1(disp_rdy1),
    .disp_rdy2(disp_rdy2), .disp_dest(disp_dest), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .squash(squash), .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_pc(iss_pc),
    .iss_dest(iss_dest), .iss_idx(iss_idx), .occupancy(occupancy)
  );
  initial clock = 0;
  always #5 clock = ~clock;
  function automatic vec_t mk(logic dv, logic [31:0] pc, logic [5:0] t1, t2, logic r1, r2,
      logic [5:0] dest, logic cv, logic [5:0] ct, logic ir, logic e_iv, logic [31:0] e_pc,
      logic [5:0] e_dest, logic [3:0] e_idx, logic [4:0] e_occ);
    vec_t v;
    v.dv = dv; v.pc = pc; v.t1 = t1; v.t2 = t2; v.r1 = r1; v.r2 = r2; v.dest = dest;
    v.cv = cv; v.ct = ct; v.ir = ir;
    v.e_iv = e_iv; v.e_pc = e_pc; v.e_dest = e_dest; v.e_idx = e_idx; v.e_occ = e_occ;
    return v;
  endfunction
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic step;
    @(posedge clock);
    #1;
  endtask
  task automatic drive(logic dv, logic [31:0] pc, logic [5:0] t1, logic r1, logic r2, logic [5:0] dest);
    disp_valid = dv; disp_pc = pc; disp_tag1 = t1; disp_tag2 = 0;
    disp_rdy1 = r1; disp_rdy2 = r2; disp_dest = dest;
  endtask
  task automatic chk_out(string n, logic iv, logic [31:0] p, logic [4:0] occ, logic dr);
    chk({n, " iss_valid"}, 32'(iss_valid), 32'(iv));
    if (iv) chk({n, " iss_pc"}, iss_pc, p);
    chk({n, " occupancy"}, 32'(occupancy), 32'(occ));
    chk({n, " disp_ready"}, 32'(disp_ready), 32'(dr));
  endtask
  initial begin
    reset = 1; squash = 0; cdb_valid = 0; cdb_tag = 0; iss_ready = 0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1 reset = 0;
    chk_out("reset", 0, 0, 0, 1);
    chk("reset iss_pc", iss_pc, 0);
    chk("reset iss_dest", 32'(iss_dest), 0);
    chk("reset iss_idx", 32'(iss_idx), 0);
    // single issue, oldest-first with stall, wakeup latency, bypass, equal-PC tie
    tbl[0]  = mk(1, 'h100, 0, 0, 1, 1, 9, 0, 0, 1,  0, 'h0,   0, 0, 1);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,      1, 'h100, 9, 15, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,      0, 'h100, 9, 15, 0);
    tbl[3]  = mk(1, 'h200, 1, 7, 1, 0, 1, 0, 0, 0,  0, 'h100, 9, 15, 1);
    tbl[4]  = mk(1, 'h180, 1, 7, 1, 0, 2, 0, 0, 0,  0, 'h100, 9, 15, 2);
    tbl[5]  = mk(1, 'h1C0, 1, 7, 1, 0, 3, 0, 0, 0,  0, 'h100, 9, 15, 3);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0,      0, 'h100, 9, 15, 3);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      1, 'h180, 2, 14, 2);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      1, 'h180, 2, 14, 2);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      1, 'h180, 2, 14, 2);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,      1, 'h1C0, 3, 13, 1);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,      1, 'h200, 1, 15, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,      0, 'h200, 1, 15, 0);
    tbl[13] = mk(1, 'h40, 5, 0, 0, 1, 4, 0, 0, 1,   0, 'h200, 1, 15, 1);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,      0, 'h200, 1, 15, 1);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 1, 5, 1,      0, 'h200, 1, 15, 1);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,      1, 'h40,  4, 15, 0);
    tbl[17] = mk(1, 'h50, 9, 0, 0, 1, 5, 1, 9, 1,   0, 'h40,  4, 15, 1);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,      1, 'h50,  5, 15, 0);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,      0, 'h50,  5, 15, 0);
    tbl[20] = mk(1, 'h60, 3, 0, 0, 1, 6, 0, 0, 1,   0, 'h50,  5, 15, 1);
    tbl[21] = mk(1, 'h60, 3, 0, 0, 1, 7, 0, 0, 1,   0, 'h50,  5, 15, 2);
    tbl[22] = mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 1,      0, 'h50,  5, 15, 2);
    tbl[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,      1, 'h60,  6, 15, 1);
    tbl[24] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,      1, 'h60,  7, 14, 0);
    tbl[25] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,      0, 'h60,  7, 14, 0);
    for (int k = 0; k < 26; k++) begin
      disp_valid = tbl[k].dv; disp_pc = tbl[k].pc; disp_tag1 = tbl[k].t1; disp_tag2 = tbl[k].t2;
      disp_rdy1 = tbl[k].r1; disp_rdy2 = tbl[k].r2; disp_dest = tbl[k].dest;
      cdb_valid = tbl[k].cv; cdb_tag = tbl[k].ct; iss_ready = tbl[k].ir;
      step;
      chk($sformatf("vec%0d iss_valid", k), 32'(iss_valid), 32'(tbl[k].e_iv));
      chk($sformatf("vec%0d iss_pc", k), iss_pc, tbl[k].e_pc);
      chk($sformatf("vec%0d iss_dest", k), 32'(iss_dest), 32'(tbl[k].e_dest));
      chk($sformatf("vec%0d iss_idx", k), 32'(iss_idx), 32'(tbl[k].e_idx));
      chk($sformatf("vec%0d occupancy", k), 32'(occupancy), 32'(tbl[k].e_occ));
      chk($sformatf("vec%0d disp_ready", k), 32'(disp_ready), 1);
    end
    cdb_valid = 0; iss_ready = 1;
    // fill all entries with non-ready ops
    for (int i = 0; i < 16; i++) begin
      drive(1, 32'h1000 + 32'(i), 6'(16 + i), 0, 1, 6'(i));
      step;
    end
    chk_out("full", 0, 0, 16, 0);
    drive(1, 'h10, 0, 1, 1, 0);
    step;
    chk_out("full drop", 0, 0, 16, 0);
    drive(0, 0, 0, 0, 0, 0);
    cdb_valid = 1; cdb_tag = 19;
    step;
    chk_out("full wake", 0, 0, 16, 0);
    cdb_valid = 0;
    step;
    chk_out("full issue", 1, 'h1003, 15, 1);
    chk("full issue idx", 32'(iss_idx), 12);
    chk("full issue dest", 32'(iss_dest), 3);
    step;
    chk_out("full drained", 0, 0, 15, 1);
    squash = 1;
    step;
    chk_out("squash clear", 0, 0, 0, 1);
    // squash with a stalled issue register and pending dispatch
    squash = 0; iss_ready = 0;
    drive(1, 'h500, 0, 1, 1, 1);
    step;
    for (int i = 0; i < 8; i++) begin
      drive(1, 32'h600 + 32'(i), 40, 0, 1, 6'(i));
      step;
    end
    chk_out("pre squash", 1, 'h500, 8, 1);
    drive(1, 'h700, 0, 1, 1, 2);
    squash = 1;
    step;
    chk_out("squash", 0, 0, 0, 1);
    squash = 0; iss_ready = 1;
    drive(0, 0, 0, 0, 0, 0);
    step;
    chk_out("post squash", 0, 0, 0, 1);
    // asynchronous reset mid-stream
    iss_ready = 0;
    drive(1, 'h310, 0, 1, 1, 1);
    step;
    drive(1, 'h320, 0, 1, 1, 2);
    step;
    drive(0, 0, 0, 0, 0, 0);
    chk_out("pre reset", 1, 'h310, 1, 1);
    #2 reset = 1;
    #1;
    chk_out("async reset", 0, 0, 0, 1);
    chk("async reset iss_pc", iss_pc, 0);
    chk("async reset iss_dest", 32'(iss_dest), 0);
    chk("async reset iss_idx", 32'(iss_idx), 0);
    #1 reset = 0;
    step;
    chk_out("after reset idle", 0, 0, 0, 1);
    iss_ready = 1;
    drive(1, 'h300, 0, 1, 1, 3);
    step;
    chk_out("after reset disp", 0, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 0);
    step;
    chk_out("after reset issue", 1, 'h300, 0, 1);
    chk("after reset dest", 32'(iss_dest), 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
